// File: rtl/calculate_voltage_pkg.sv
// Shared constants and types for the node-voltage copy stage of the circuit solver.
package calculate_voltage_pkg;

  localparam int VALID_BIT  = 63;
  localparam int REF_BIT    = 62;
  localparam int VAR_HI     = 61;
  localparam int VAR_LO     = 56;
  localparam int MATRIX_DIM = 64;
  localparam int MAX_NODES  = 32;

  localparam logic [31:0] FLOAT_ZERO = 32'h0000_0000;

  typedef enum logic [2:0] {
    IDLE,
    HEAD_ADDR,
    HEAD_WAIT,
    MAT_ADDR,
    MAT_WAIT,
    WRITE,
    DONE
  } state_t;

endpackage

// File: rtl/calculate_voltage_rd_wait_counter.sv
// Down-counter that times a RAM read: load on the address cycle, expired on the
// wait cycle in which q is valid.
module rd_wait_counter #(
  parameter int unsigned RD_LAT = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic load,
  input  logic en,
  output logic expired
);

  localparam int CW = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;

  logic [CW-1:0] cnt;

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values; blocking here would create order-dependent simulation.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= CW'(RD_LAT - 1);
    end else if (en && (cnt != '0)) begin
      cnt <= cnt - CW'(1);
    end
  end

  assign expired = en && (cnt == '0);

endmodule

// File: rtl/calculate_voltage.sv
// Walks the node list and copies each node's solution value from the solved
// matrix into the nodeVoltage RAM; reference and invalid nodes get +0.0.
module calculate_voltage
  import calculate_voltage_pkg::*;
#(
  parameter int unsigned RD_LAT  = 2,
  parameter int unsigned RHS_COL = 63
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        run_calculateVoltage,
  input  logic [5:0]  num_nodes,
  input  logic [63:0] nodeHeads_q,
  input  logic [31:0] matrix_q_a,
  output logic [4:0]  stage8_nodeHeads_addr,
  output logic        stage8_nodeHeads_wren,
  output logic [11:0] stage8_matrix_addr_a,
  output logic        stage8_matrix_wren_a,
  output logic [4:0]  stage8_nodeVoltage_addr,
  output logic [31:0] stage8_nodeVoltage_data,
  output logic        stage8_nodeVoltage_wren,
  output logic        done_calculateVoltage
);

  state_t      state, state_nx;
  logic [5:0]  idx, idx_nx;
  logic [5:0]  n_nodes, n_nx;
  logic [5:0]  num_clamped;
  logic [11:0] maddr_nx;
  logic [31:0] data_nx;
  logic        wren_nx, done_nx;
  logic        wait_expired;
  logic        unused_head_bits;

  assign stage8_nodeHeads_wren = 1'b0;
  assign stage8_matrix_wren_a  = 1'b0;
  assign unused_head_bits      = ^nodeHeads_q[VAR_LO-1:0];

  assign num_clamped = (num_nodes > 6'(MAX_NODES)) ? 6'(MAX_NODES) : num_nodes;

  rd_wait_counter #(.RD_LAT(RD_LAT)) u_rd_wait (
    .clk     (clk),
    .reset   (reset),
    .load    ((state == HEAD_ADDR) || (state == MAT_ADDR)),
    .en      ((state == HEAD_WAIT) || (state == MAT_WAIT)),
    .expired (wait_expired)
  );

  // Next-state logic also computes the next value of every output so that the
  // outputs can be registered without adding a cycle of latency.
  // NOTE: every variable gets a default before the case; a missed branch would
  // otherwise infer a latch.
  always_comb begin
    state_nx = state;
    idx_nx   = idx;
    n_nx     = n_nodes;
    maddr_nx = stage8_matrix_addr_a;
    data_nx  = stage8_nodeVoltage_data;

    unique case (state)
      IDLE: begin
        if (run_calculateVoltage) begin
          idx_nx   = '0;
          n_nx     = num_clamped;
          state_nx = (num_clamped == '0) ? DONE : HEAD_ADDR;
        end
      end
      HEAD_ADDR: state_nx = HEAD_WAIT;
      HEAD_WAIT: begin
        if (wait_expired) begin
          if (!nodeHeads_q[VALID_BIT] || nodeHeads_q[REF_BIT]) begin
            data_nx  = FLOAT_ZERO;
            state_nx = WRITE;
          end else begin
            maddr_nx = {nodeHeads_q[VAR_HI:VAR_LO], 6'(RHS_COL)};
            state_nx = MAT_ADDR;
          end
        end
      end
      MAT_ADDR: state_nx = MAT_WAIT;
      MAT_WAIT: begin
        if (wait_expired) begin
          data_nx  = matrix_q_a;
          state_nx = WRITE;
        end
      end
      WRITE: begin
        idx_nx   = idx + 6'd1;
        state_nx = (idx_nx == n_nodes) ? DONE : HEAD_ADDR;
      end
      DONE: begin
        if (!run_calculateVoltage) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase

    // Losing run abandons the pass; already-written nodes stay written.
    if (!run_calculateVoltage && (state != IDLE)) state_nx = IDLE;

    wren_nx = (state_nx == WRITE);
    done_nx = (state_nx == DONE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state                   <= IDLE;
      idx                     <= '0;
      n_nodes                 <= '0;
      stage8_nodeHeads_addr   <= '0;
      stage8_matrix_addr_a    <= '0;
      stage8_nodeVoltage_addr <= '0;
      stage8_nodeVoltage_data <= FLOAT_ZERO;
      stage8_nodeVoltage_wren <= 1'b0;
      done_calculateVoltage   <= 1'b0;
    end else begin
      state                   <= state_nx;
      idx                     <= idx_nx;
      n_nodes                 <= n_nx;
      stage8_nodeHeads_addr   <= idx_nx[4:0];
      stage8_matrix_addr_a    <= maddr_nx;
      stage8_nodeVoltage_addr <= idx_nx[4:0];
      stage8_nodeVoltage_data <= data_nx;
      stage8_nodeVoltage_wren <= wren_nx;
      done_calculateVoltage   <= done_nx;
    end
  end

endmodule

// File: tb/tb_calculate_voltage.sv
// Bench for calculate_voltage: RAM models with two-cycle reads, a write
// scoreboard, and done-latency measurement.
module tb_calculate_voltage;

  logic        clk = 1'b0;
  logic        reset;
  logic        run_calculateVoltage;
  logic [5:0]  num_nodes;
  logic [63:0] nodeHeads_q;
  logic [31:0] matrix_q_a;
  logic [4:0]  stage8_nodeHeads_addr;
  logic        stage8_nodeHeads_wren;
  logic [11:0] stage8_matrix_addr_a;
  logic        stage8_matrix_wren_a;
  logic [4:0]  stage8_nodeVoltage_addr;
  logic [31:0] stage8_nodeVoltage_data;
  logic        stage8_nodeVoltage_wren;
  logic        done_calculateVoltage;

  calculate_voltage #(.RD_LAT(2), .RHS_COL(63)) dut (
    .clk                     (clk),
    .reset                   (reset),
    .run_calculateVoltage    (run_calculateVoltage),
    .num_nodes               (num_nodes),
    .nodeHeads_q             (nodeHeads_q),
    .matrix_q_a              (matrix_q_a),
    .stage8_nodeHeads_addr   (stage8_nodeHeads_addr),
    .stage8_nodeHeads_wren   (stage8_nodeHeads_wren),
    .stage8_matrix_addr_a    (stage8_matrix_addr_a),
    .stage8_matrix_wren_a    (stage8_matrix_wren_a),
    .stage8_nodeVoltage_addr (stage8_nodeVoltage_addr),
    .stage8_nodeVoltage_data (stage8_nodeVoltage_data),
    .stage8_nodeVoltage_wren (stage8_nodeVoltage_wren),
    .done_calculateVoltage   (done_calculateVoltage)
  );

  always #5 clk = ~clk;

  // RAM models: address registered, then output registered (two-cycle read).
  logic [63:0] heads [32];
  logic [31:0] mat [4096];
  logic [63:0] h_s1;
  logic [31:0] m_s1;
  always @(posedge clk) begin
    h_s1        <= heads[stage8_nodeHeads_addr];
    nodeHeads_q <= h_s1;
    m_s1        <= mat[stage8_matrix_addr_a];
    matrix_q_a  <= m_s1;
  end

  int cyc = 0;
  always @(posedge clk) cyc++;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  typedef struct packed {
    logic [4:0]  addr;
    logic [31:0] data;
  } wr_t;

  wr_t exp_q[$];
  int  n_writes = 0;
  logic prev_wren = 1'b0;
  logic [11:0] watch_maddr = 12'hFFF;
  logic saw_watch = 1'b0;

  // Write monitor: every strobe must match the next expected write.
  always @(negedge clk) begin
    if (stage8_matrix_addr_a == watch_maddr) saw_watch = 1'b1;
    if (stage8_nodeVoltage_wren) begin
      wr_t e;
      n_writes++;
      check("wren_single_cycle", prev_wren, 1'b0);
      check("write_expected", exp_q.size() != 0, 1'b1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check("write_addr_data", {stage8_nodeVoltage_addr, stage8_nodeVoltage_data},
              {e.addr, e.data});
      end
    end
    prev_wren = stage8_nodeVoltage_wren;
  end

  function automatic logic [63:0] head(input bit v, input bit r, input logic [5:0] vi);
    return {v, r, vi, 56'hA5_5A5A_A5A5_5A5A};
  endfunction

  function automatic logic [57:0] all_outs();
    return {stage8_nodeHeads_addr, stage8_nodeHeads_wren, stage8_matrix_addr_a,
            stage8_matrix_wren_a, stage8_nodeVoltage_addr, stage8_nodeVoltage_data,
            stage8_nodeVoltage_wren, done_calculateVoltage};
  endfunction

  task automatic push(input int a, input logic [31:0] d);
    wr_t e;
    e.addr = 5'(a);
    e.data = d;
    exp_q.push_back(e);
  endtask

  task automatic start_run(input logic [5:0] n, output int start);
    num_nodes = n;
    run_calculateVoltage = 1'b1;
    start = cyc;
  endtask

  task automatic wait_done(input string tag, input int start, input int exp_lat);
    int got = -1;
    for (int i = 0; i < 600 && got < 0; i++) begin
      @(negedge clk);
      if (done_calculateVoltage) got = cyc - start;
    end
    check(tag, 64'(got), 64'(exp_lat));
  endtask

  task automatic stop_run();
    run_calculateVoltage = 1'b0;
    @(negedge clk);
    check("done_drops", done_calculateVoltage, 1'b0);
  endtask

  task automatic load_mixed();
    heads[0] = head(1, 1, 6'd9);
    heads[1] = head(1, 0, 6'd0);
    heads[2] = head(1, 0, 6'd1);
    mat[{6'd0, 6'd63}] = 32'h40A0_0000;
    mat[{6'd1, 6'd63}] = 32'h3F80_0000;
  endtask

  initial begin
    int start;
    int w0;
    for (int i = 0; i < 32; i++) heads[i] = '0;
    for (int i = 0; i < 4096; i++) mat[i] = '0;
    reset = 1'b1;
    run_calculateVoltage = 1'b0;
    num_nodes = '0;
    repeat (2) @(negedge clk);
    check("reset_outputs", 64'(all_outs()), 64'd0);
    reset = 1'b0;

    // Reset asserted during an active run, before any write can occur.
    load_mixed();
    start_run(6'd3, start);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    check("reset_mid_run", 64'(all_outs()), 64'd0);
    reset = 1'b0;
    run_calculateVoltage = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("idle_after_reset", {stage8_nodeVoltage_wren, done_calculateVoltage}, 2'b00);
    end

    // Mixed nodes: ref, then two solved values.
    push(0, 32'h0);
    push(1, 32'h40A0_0000);
    push(2, 32'h3F80_0000);
    w0 = n_writes;
    start_run(6'd3, start);
    wait_done("mixed_latency", start, 19);
    check("mixed_all_written", exp_q.size(), 0);
    check("mixed_write_count", n_writes - w0, 3);
    repeat (3) @(negedge clk);
    check("done_holds", done_calculateVoltage, 1'b1);
    check("ro_wrens", {stage8_nodeHeads_wren, stage8_matrix_wren_a}, 2'b00);
    stop_run();

    // Empty list.
    w0 = n_writes;
    start_run(6'd0, start);
    wait_done("empty_latency", start, 1);
    check("empty_no_writes", n_writes - w0, 0);
    stop_run();

    // Abort during node1's MAT_WAIT, then a fresh full pass.
    push(0, 32'h0);
    w0 = n_writes;
    start_run(6'd3, start);
    repeat (9) @(negedge clk);
    run_calculateVoltage = 1'b0;
    repeat (12) @(negedge clk);
    check("abort_write_count", n_writes - w0, 1);
    check("abort_no_pending", exp_q.size(), 0);
    check("abort_no_done", done_calculateVoltage, 1'b0);
    push(0, 32'h0);
    push(1, 32'h40A0_0000);
    push(2, 32'h3F80_0000);
    start_run(6'd3, start);
    wait_done("restart_latency", start, 19);
    check("restart_all_written", exp_q.size(), 0);
    stop_run();

    // Full list at 32, then an over-range count that must clamp to 32.
    for (int i = 0; i < 32; i++) begin
      heads[i] = head(1, 0, 6'(i));
      mat[{6'(i), 6'd63}] = 32'(i);
    end
    for (int pass = 0; pass < 2; pass++) begin
      for (int i = 0; i < 32; i++) push(i, 32'(i));
      w0 = n_writes;
      start_run(pass == 0 ? 6'd32 : 6'd63, start);
      @(negedge clk);
      num_nodes = 6'd3;
      wait_done(pass == 0 ? "full_latency" : "clamp_latency", start, 225);
      check("full_write_count", n_writes - w0, 32);
      check("full_all_written", exp_q.size(), 0);
      stop_run();
    end

    // Invalid node with a nonzero var_idx must not trigger a matrix read.
    heads[0] = head(1, 0, 6'd2);
    heads[1] = head(0, 0, 6'd5);
    heads[2] = head(1, 1, 6'd7);
    mat[{6'd2, 6'd63}] = 32'hC0490FDB;
    mat[{6'd5, 6'd63}] = 32'hDEAD_BEEF;
    watch_maddr = {6'd5, 6'd63};
    saw_watch = 1'b0;
    push(0, 32'hC0490FDB);
    push(1, 32'h0);
    push(2, 32'h0);
    start_run(6'd3, start);
    wait_done("invalid_latency", start, 16);
    check("invalid_all_written", exp_q.size(), 0);
    check("invalid_no_mat_read", saw_watch, 1'b0);
    stop_run();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
